// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// bcd_max gives the largest value the digit field can show, clipped to the input range.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic {
    IDLE,
    CONVERT
  } bcd_state_e;

  localparam bcd_digit_t BCD_NINE = 4'd9;

  localparam int BCD_WIDE = 256;
  typedef logic [BCD_WIDE-1:0] bcd_wide_t;

  function automatic bcd_wide_t bcd_max(
    input int width,
    input int digits
  );
    bcd_wide_t lim;
    bcd_wide_t val;
    if (width >= BCD_WIDE) lim = '1;
    else lim = (bcd_wide_t'(1) << width)
             - bcd_wide_t'(1);
    val = '0;
    for (int d = 0; d < digits; d++) begin
      if (val > (lim - bcd_wide_t'(9))
                / bcd_wide_t'(10))
        return lim;
      val = val * bcd_wide_t'(10)
          + bcd_wide_t'(9);
    end
    return val;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more.
// Four-bit result, any carry out is dropped.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  output bcd_digit_t adjusted
);

  assign adjusted = (digit >= 4'd5)
                  ? digit + 4'd3
                  : digit;

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock,
// with start/done handshake, overflow saturation and leading-zero mask.
module binary_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic [DIGITS-1:0]     lz_mask
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = 4 * DIGITS;
  localparam bcd_wide_t MAX_W = bcd_max(WIDTH, DIGITS);
  localparam bcd_wide_t LIM_W =
    (bcd_wide_t'(1) << WIDTH) - bcd_wide_t'(1);
  localparam logic [WIDTH-1:0] MAX = MAX_W[WIDTH-1:0];
  localparam bit OVF_POSSIBLE = MAX_W < LIM_W;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [DW-1:0] SAT = {DIGITS{BCD_NINE}};
  localparam logic [DIGITS-1:0] LZ_RST =
    {DIGITS{1'b1}} << 1;

  bcd_state_e        state_q;
  bcd_state_e        state_d;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  shift_q;
  logic [DW-1:0]     dig_q;
  logic [DW-1:0]     adj;
  logic [DW-1:0]     dig_nxt;
  logic [DW-1:0]     bcd_load;
  logic [DIGITS-1:0] lz_nxt;
  logic              zero_above;
  logic              ovf_q;
  logic              ovf_fin;
  logic              ovf_cmp;
  logic              last;

  if (OVF_POSSIBLE) begin : g_ovf
    assign ovf_cmp = binary > MAX;
  end else begin : g_no_ovf
    assign ovf_cmp = 1'b0;
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit    (dig_q[4*g +: 4]),
      .adjusted (adj[4*g +: 4])
    );
  end

  assign last    = cnt_q == LAST;
  assign dig_nxt = {adj[DW-2:0], shift_q[WIDTH-1]};
  // A bit leaving the top digit only happens on overflow.
  assign ovf_fin = ovf_q | adj[DW-1];
  assign bcd_load = ovf_fin ? SAT : dig_nxt;

  always_comb begin
    lz_nxt     = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above
                 & (bcd_load[4*i +: 4] == 4'd0);
      lz_nxt[i]  = zero_above;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CONVERT;
      CONVERT: if (last)  state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    unique case (state_q)
      IDLE:    busy = 1'b0;
      CONVERT: busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      shift_q  <= '0;
      dig_q    <= '0;
      ovf_q    <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      lz_mask  <= LZ_RST;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            shift_q <= binary;
            dig_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= ovf_cmp;
          end
        end
        CONVERT: begin
          shift_q <= shift_q << 1;
          dig_q   <= dig_nxt;
          cnt_q   <= cnt_q + CW'(1);
          ovf_q   <= ovf_fin;
          if (last) begin
            bcd      <= bcd_load;
            overflow <= ovf_fin;
            lz_mask  <= lz_nxt;
            done     <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Scoreboard bench for binary_to_bcd_seq: a 32-bit/10-digit and a
// 7-bit/2-digit instance, directed vectors with hand-computed digits.
module tb_binary_to_bcd_seq;

  localparam int WA = 32;
  localparam int DA = 10;
  localparam int WB = 7;
  localparam int DB = 2;

  typedef struct {
    logic [4*DA-1:0] bcd;
    logic            ovf;
    logic [DA-1:0]   lz;
    int              due;
  } exp_a_t;

  typedef struct {
    logic [4*DB-1:0] bcd;
    logic            ovf;
    logic [DB-1:0]   lz;
    int              due;
  } exp_b_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic            start_a = 1'b0;
  logic [WA-1:0]   bin_a = '0;
  logic            busy_a, done_a, ovf_a;
  logic [4*DA-1:0] bcd_a;
  logic [DA-1:0]   lz_a;

  logic            start_b = 1'b0;
  logic [WB-1:0]   bin_b = '0;
  logic            busy_b, done_b, ovf_b;
  logic [4*DB-1:0] bcd_b;
  logic [DB-1:0]   lz_b;

  exp_a_t q_a[$];
  exp_b_t q_b[$];
  exp_a_t ea;
  exp_b_t eb;
  int cyc = 0;
  int passed = 0;
  int total = 0;
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  binary_to_bcd_seq #(.WIDTH(WA), .DIGITS(DA)) u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_a),
    .binary   (bin_a),
    .busy     (busy_a),
    .done     (done_a),
    .bcd      (bcd_a),
    .overflow (ovf_a),
    .lz_mask  (lz_a)
  );

  binary_to_bcd_seq #(.WIDTH(WB), .DIGITS(DB)) u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_b),
    .binary   (bin_b),
    .busy     (busy_b),
    .done     (done_b),
    .bcd      (bcd_b),
    .overflow (ovf_b),
    .lz_mask  (lz_b)
  );

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    total++;
    if (act !== req)
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    else passed++;
  endtask

  always @(negedge clk) begin
    if (rst_n && done_a) begin
      if (q_a.size() == 0) begin
        check("a_spurious_done", 1, 0);
      end else begin
        ea = q_a.pop_front();
        check("a_bcd", 64'(bcd_a), 64'(ea.bcd));
        check("a_ovf", 64'(ovf_a), 64'(ea.ovf));
        check("a_lz", 64'(lz_a), 64'(ea.lz));
        check("a_latency", 64'(cyc), 64'(ea.due));
        check("a_busy_low", 64'(busy_a), 0);
        check("a_pulse", 64'(prev_a), 0);
      end
    end
    prev_a = done_a;
  end

  always @(negedge clk) begin
    if (rst_n && done_b) begin
      if (q_b.size() == 0) begin
        check("b_spurious_done", 1, 0);
      end else begin
        eb = q_b.pop_front();
        check("b_bcd", 64'(bcd_b), 64'(eb.bcd));
        check("b_ovf", 64'(ovf_b), 64'(eb.ovf));
        check("b_lz", 64'(lz_b), 64'(eb.lz));
        check("b_latency", 64'(cyc), 64'(eb.due));
        check("b_pulse", 64'(prev_b), 0);
      end
    end
    prev_b = done_b;
  end

  task automatic push_a(input logic [4*DA-1:0] e,
                        input logic o,
                        input logic [DA-1:0] lz);
    exp_a_t x;
    x.bcd = e; x.ovf = o; x.lz = lz; x.due = cyc + WA;
    q_a.push_back(x);
  endtask

  task automatic issue_a(input logic [WA-1:0] v,
                         input logic [4*DA-1:0] e,
                         input logic o,
                         input logic [DA-1:0] lz);
    @(negedge clk);
    start_a = 1'b1;
    bin_a   = v;
    @(posedge clk);
    #1;
    push_a(e, o, lz);
    start_a = 1'b0;
    check("a_busy_high", 64'(busy_a), 1);
  endtask

  task automatic issue_b(input logic [WB-1:0] v,
                         input logic [4*DB-1:0] e,
                         input logic o,
                         input logic [DB-1:0] lz);
    exp_b_t x;
    @(negedge clk);
    start_b = 1'b1;
    bin_b   = v;
    @(posedge clk);
    #1;
    x.bcd = e; x.ovf = o; x.lz = lz; x.due = cyc + WB;
    q_b.push_back(x);
    start_b = 1'b0;
    check("b_busy_high", 64'(busy_b), 1);
  endtask

  task automatic wait_a(input string name);
    int n;
    n = 0;
    while (q_a.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q_a.size() != 0) check(name, 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_b(input string name);
    int n;
    n = 0;
    while (q_b.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q_b.size() != 0) check(name, 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_done_a(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!done_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done_a) check(name, 0, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_a_busy", 64'(busy_a), 0);
    check("rst_a_done", 64'(done_a), 0);
    check("rst_a_bcd", 64'(bcd_a), 0);
    check("rst_a_ovf", 64'(ovf_a), 0);
    check("rst_a_lz", 64'(lz_a), 64'(10'b1111111110));
    check("rst_b_bcd", 64'(bcd_b), 0);
    check("rst_b_lz", 64'(lz_b), 64'(2'b10));
    rst_n = 1'b1;
    @(negedge clk);

    issue_b(7'd42, 8'h42, 1'b0, 2'b00);
    wait_b("b_timeout_42");
    issue_b(7'd127, 8'h99, 1'b1, 2'b00);
    wait_b("b_timeout_127");
    issue_b(7'd0, 8'h00, 1'b0, 2'b10);
    wait_b("b_timeout_0");
    issue_b(7'd99, 8'h99, 1'b0, 2'b00);
    wait_b("b_timeout_99");
    issue_b(7'd7, 8'h07, 1'b0, 2'b10);
    wait_b("b_timeout_7");
    issue_b(7'd100, 8'h99, 1'b1, 2'b00);
    wait_b("b_timeout_100");

    issue_a(32'd4294967295, 40'h4294967295,
            1'b0, 10'b0000000000);
    wait_a("a_timeout_max");
    issue_a(32'd1234, 40'h0000001234,
            1'b0, 10'b1111110000);
    wait_a("a_timeout_1234");
    issue_a(32'd0, 40'h0, 1'b0, 10'b1111111110);
    wait_a("a_timeout_0");

    issue_a(32'd1000, 40'h0000001000,
            1'b0, 10'b1111110000);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start_a = 1'b1;
    bin_a   = 32'd55;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    wait_a("a_timeout_ignore");

    @(negedge clk);
    start_a = 1'b1;
    bin_a   = 32'd7;
    @(posedge clk);
    #1;
    push_a(40'h7, 1'b0, 10'b1111111110);
    wait_done_a("a_timeout_b2b0");
    bin_a = 32'd99999;
    @(posedge clk);
    #1;
    push_a(40'h99999, 1'b0, 10'b1111100000);
    wait_done_a("a_timeout_b2b1");
    bin_a = 32'd3000000000;
    @(posedge clk);
    #1;
    push_a(40'h3000000000, 1'b0, 10'b0000000000);
    start_a = 1'b0;
    wait_a("a_timeout_b2b2");

    issue_a(32'd123456, 40'h123456,
            1'b0, 10'b1111000000);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    q_a.delete();
    check("mid_rst_busy", 64'(busy_a), 0);
    check("mid_rst_done", 64'(done_a), 0);
    check("mid_rst_bcd", 64'(bcd_a), 0);
    check("mid_rst_ovf", 64'(ovf_a), 0);
    check("mid_rst_lz", 64'(lz_a),
          64'(10'b1111111110));
    check("mid_rst_b_bcd", 64'(bcd_b), 0);
    check("mid_rst_b_ovf", 64'(ovf_b), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("mid_rst_no_done", 64'(bcd_a), 0);

    issue_a(32'd65535, 40'h65535,
            1'b0, 10'b1111100000);
    wait_a("a_timeout_post_rst");

    check("queues_empty",
          64'(q_a.size() + q_b.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
